// File: rtl/id_disp_pkg.sv
// Shared types and constants for the student-ID display scanner.
// Holds the frame FSM states and the active-low hex segment table.
package id_disp_pkg;

  typedef enum logic [1:0] {
    SEARCH,
    FILL,
    CHECK
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Indexed by hex digit; {g,f,e,d,c,b,a}, low = lit
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/id_display_scanner_hex.sv
// Combinational hex digit to active-low seven-segment decode.
// Pure table lookup; the caller registers the result.
module hex_to_seg7
  import id_disp_pkg::*;
(
  input  logic [3:0] d_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_LUT[d_i];

endmodule

// File: rtl/id_display_scanner.sv
// Frame-locks on the ID digit stream, buffers one frame, verifies
// later frames against it and scans the buffer onto the display.
module id_display_scanner
  import id_disp_pkg::*;
#(
  parameter int          NUM_DIGITS  = 8,
  parameter int          SCAN_DIV_W  = 2,
  parameter logic [3:0]  START_DIGIT = 4'hA
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            id,
  input  logic                  sample,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_valid,
  output logic                  mismatch
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = IW + SCAN_DIV_W;
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            fv_q, fv_d;
  logic            mm_q, mm_d;
  logic [CW-1:0]   cnt_q;
  logic [6:0]      seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [3:0]      buf_q [NUM_DIGITS];
  logic            wr_en;
  logic [IW-1:0]   pos;
  logic [6:0]      dec;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    fv_d    = fv_q;
    mm_d    = mm_q;
    wr_en   = 1'b0;
    if (sample) begin
      unique case (state_q)
        SEARCH: begin
          if (id == START_DIGIT) begin
            wr_en   = 1'b1;
            idx_d   = IW'(1);
            state_d = FILL;
          end
        end
        FILL: begin
          wr_en = 1'b1;
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST) begin
            fv_d    = 1'b1;
            state_d = CHECK;
          end
        end
        CHECK: begin
          if (id != buf_q[idx_q]) begin
            mm_d    = 1'b1;
            fv_d    = 1'b0;
            idx_d   = '0;
            state_d = SEARCH;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  // Buffer carries no reset: it is only read once frame_valid is set
  always_ff @(posedge clk) begin
    if (wr_en) buf_q[idx_q] <= id;
  end

  assign pos = cnt_q[CW-1 -: IW];

  hex_to_seg7 u_hex (
    .d_i   (buf_q[pos]),
    .seg_o (dec)
  );

  // Position 0 is leftmost, so its enable is the top bit (~pos)
  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = '1;
    if (fv_q) begin
      seg_d     = dec;
      an_d[~pos] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SEARCH;
      idx_q   <= '0;
      fv_q    <= 1'b0;
      mm_q    <= 1'b0;
      cnt_q   <= '0;
      seg_q   <= SEG_BLANK;
      an_q    <= '1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fv_q    <= fv_d;
      mm_q    <= mm_d;
      cnt_q   <= cnt_q + 1'b1;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign frame_valid = fv_q;
  assign mismatch    = mm_q;

endmodule

// File: tb/tb_id_display_scanner.sv
// Directed bench for id_display_scanner: lock, relock, gating,
// async reset and scan timing with hand-derived expectations.
module tb_id_display_scanner;

  logic       clk;
  logic       reset;
  logic [3:0] id;
  logic       sample;
  logic [6:0] seg;
  logic [7:0] an;
  logic       frame_valid;
  logic       mismatch;

  int total = 0;
  int bad   = 0;
  int sp    = 0;
  int ecount;

  logic [3:0] seq [8] = '{4'hA, 4'hB, 4'h1, 4'h5,
                          4'h7, 4'h0, 4'hC, 4'h4};

  id_display_scanner dut (
    .clk         (clk),
    .reset       (reset),
    .id          (id),
    .sample      (sample),
    .seg         (seg),
    .an          (an),
    .frame_valid (frame_valid),
    .mismatch    (mismatch)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Edges since reset release: the expected scan position source
  always @(posedge clk or posedge reset) begin
    if (reset) ecount <= 0;
    else       ecount <= ecount + 1;
  end

  function automatic logic [6:0] lut(input logic [3:0] d);
    case (d)
      4'h0: lut = 7'h40; 4'h1: lut = 7'h79;
      4'h2: lut = 7'h24; 4'h3: lut = 7'h30;
      4'h4: lut = 7'h19; 4'h5: lut = 7'h12;
      4'h6: lut = 7'h02; 4'h7: lut = 7'h78;
      4'h8: lut = 7'h00; 4'h9: lut = 7'h10;
      4'hA: lut = 7'h08; 4'hB: lut = 7'h03;
      4'hC: lut = 7'h46; 4'hD: lut = 7'h21;
      4'hE: lut = 7'h06; default: lut = 7'h0E;
    endcase
  endfunction

  task automatic drive(input logic [3:0] d, input logic s);
    id = d;
    sample = s;
    @(posedge clk);
    #1;
  endtask

  task automatic feed();
    drive(seq[sp], 1'b1);
    sp = (sp + 1) % 8;
  endtask

  task automatic do_reset(input int start);
    @(negedge clk);
    reset = 1;
    id = 0;
    sample = 0;
    @(negedge clk);
    reset = 0;
    sp = start;
  endtask

  task automatic chk_fv(input string nm, input logic exp);
    total++;
    if (frame_valid !== exp) begin
      bad++;
      $display("FAIL %s frame_valid got=%b exp=%b", nm, frame_valid, exp);
    end
  endtask

  task automatic chk_mm(input string nm, input logic exp);
    total++;
    if (mismatch !== exp) begin
      bad++;
      $display("FAIL %s mismatch got=%b exp=%b", nm, mismatch, exp);
    end
  endtask

  task automatic check_display(input int n);
    int p;
    logic [7:0] ea;
    for (int i = 0; i < n; i++) begin
      feed();
      p = ((ecount - 1) % 32) / 4;
      ea = ~(8'h80 >> p);
      total++;
      if (an !== ea || seg !== lut(seq[p])) begin
        bad++;
        $display("FAIL display an=%h seg=%h exp an=%h seg=%h",
                 an, seg, ea, lut(seq[p]));
      end
    end
  endtask

  task automatic test_reset();
    reset = 1;
    id = 0;
    sample = 0;
    #12;
    total++;
    if (seg !== 7'h7F || an !== 8'hFF) begin
      bad++;
      $display("FAIL reset_disp seg=%h an=%h exp 7f ff", seg, an);
    end
    chk_fv("reset", 1'b0);
    chk_mm("reset", 1'b0);
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_clean_lock();
    do_reset(0);
    for (int i = 0; i < 7; i++) feed();
    chk_fv("lock_pre", 1'b0);
    feed();
    chk_fv("lock", 1'b1);
    check_display(32);
    for (int i = 0; i < 80; i++) begin
      feed();
      total++;
      if (mismatch !== 1'b0 || frame_valid !== 1'b1) begin
        bad++;
        $display("FAIL steady mm=%b fv=%b exp 0 1",
                 mismatch, frame_valid);
      end
    end
  endtask

  task automatic test_corruption();
    while (sp != 6) feed();
    drive(4'hD, 1'b1);
    sp = 7;
    chk_mm("corrupt", 1'b1);
    chk_fv("corrupt", 1'b0);
    feed();
    total++;
    if (seg !== 7'h7F || an !== 8'hFF) begin
      bad++;
      $display("FAIL corrupt_blank seg=%h an=%h exp 7f ff", seg, an);
    end
    for (int i = 0; i < 7; i++) feed();
    chk_fv("relock_pre", 1'b0);
    feed();
    chk_fv("relock", 1'b1);
    chk_mm("relock_sticky", 1'b1);
  endtask

  task automatic test_midstream();
    do_reset(3);
    for (int i = 0; i < 12; i++) feed();
    chk_fv("mid_pre", 1'b0);
    feed();
    chk_fv("mid_lock", 1'b1);
    chk_mm("mid_lock", 1'b0);
    check_display(32);
  endtask

  task automatic test_sample_gating();
    do_reset(0);
    feed();
    for (int i = 1; i < 8; i++) begin
      drive(4'hF, 1'b0);
      if (i == 7) chk_fv("gate_pre", 1'b0);
      feed();
    end
    chk_fv("gate_lock", 1'b1);
    check_display(32);
  endtask

  task automatic test_async_reset();
    do_reset(0);
    for (int i = 0; i < 3; i++) feed();
    id = seq[3];
    sample = 1;
    #2 reset = 1;
    #1;
    total++;
    if (seg !== 7'h7F || an !== 8'hFF) begin
      bad++;
      $display("FAIL arst_fill seg=%h an=%h exp 7f ff", seg, an);
    end
    chk_fv("arst_fill", 1'b0);
    @(negedge clk);
    reset = 0;
    sp = 0;
    for (int i = 0; i < 7; i++) feed();
    chk_fv("arst_relock_pre", 1'b0);
    feed();
    chk_fv("arst_relock", 1'b1);
    check_display(8);
    #2 reset = 1;
    #1;
    total++;
    if (seg !== 7'h7F || an !== 8'hFF || frame_valid !== 1'b0) begin
      bad++;
      $display("FAIL arst_check seg=%h an=%h fv=%b exp 7f ff 0",
               seg, an, frame_valid);
    end
    @(negedge clk);
    reset = 0;
    sp = 0;
    for (int i = 0; i < 8; i++) feed();
    chk_fv("arst_check_relock", 1'b1);
    check_display(8);
  endtask

  task automatic test_scan_timing();
    logic [7:0] a [72];
    int f;
    for (int t = 0; t < 72; t++) begin
      feed();
      a[t] = an;
      total++;
      if ($countones(~an) != 1) begin
        bad++;
        $display("FAIL scan_onehot an=%h exp one low bit", an);
      end
    end
    f = 1;
    while (f < 8 && a[f] == a[f-1]) f++;
    for (int t = f + 1; t < 72; t++) begin
      total++;
      if ((a[t] != a[t-1]) !== ((t - f) % 4 == 0)) begin
        bad++;
        $display("FAIL scan_dwell t=%0d an=%h prev=%h", t, a[t], a[t-1]);
      end
    end
    for (int t = 32; t < 72; t++) begin
      total++;
      if (a[t] !== a[t-32]) begin
        bad++;
        $display("FAIL scan_period an=%h exp %h", a[t], a[t-32]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_corruption();
    test_midstream();
    test_sample_gating();
    test_async_reset();
    test_scan_timing();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
